// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared opcodes, encodings, states and control word for the multicycle controller
package mips_ctrl_pkg;

  // Opcode field values, instr[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // ALU operation codes (low three bits of aluop)
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_SLT   = 3'b011;
  localparam logic [2:0] ALU_AND   = 3'b100;
  localparam logic [2:0] ALU_OR    = 3'b101;
  localparam logic [2:0] ALU_XOR   = 3'b110;

  // ALU B operand select
  localparam logic [1:0] SRCB_RT    = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  // Next-PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_RTEXE, S_ALUWB, S_IMMEXE, S_BEQ, S_JUMP, S_TRAP
  } state_t;

  // Raw per-state control word before handshake/timeout gating
  typedef struct packed {
    logic       pcwrite;
    logic       branch;
    logic       iord;
    logic       mem_req;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       regwrite;
    logic       memtoreg;
    logic       link;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] aluop;
    logic       hassign;
    logic       islui;
    logic       illegal;
  } ctrl_word_t;

  function automatic logic is_imm_op(input logic [5:0] op);
    return (op == OP_ADDI) || (op == OP_ADDIU) || (op == OP_SLTI) ||
           (op == OP_SLTIU) || (op == OP_ANDI) || (op == OP_ORI) ||
           (op == OP_XORI) || (op == OP_LUI);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - opcode/memory handshake inputs and datapath control outputs
interface multicycle_ctrl_if #(
  parameter int ALUOP_W = 3
);
  logic [5:0]         op;
  logic               mem_ready;
  logic               pcwrite;
  logic               branch;
  logic               iord;
  logic               mem_req;
  logic               memwrite;
  logic               irwrite;
  logic               regdst;
  logic               regwrite;
  logic               memtoreg;
  logic               link;
  logic               alusrca;
  logic [1:0]         alusrcb;
  logic [1:0]         pcsrc;
  logic [ALUOP_W-1:0] aluop;
  logic               hassign;
  logic               islui;
  logic               illegal;
  logic               bus_err;

  // Controller side
  modport master (
    input  op, mem_ready,
    output pcwrite, branch, iord, mem_req, memwrite, irwrite, regdst,
           regwrite, memtoreg, link, alusrca, alusrcb, pcsrc, aluop,
           hassign, islui, illegal, bus_err
  );

  // Datapath side
  modport slave (
    output op, mem_ready,
    input  pcwrite, branch, iord, mem_req, memwrite, irwrite, regdst,
           regwrite, memtoreg, link, alusrca, alusrcb, pcsrc, aluop,
           hassign, islui, illegal, bus_err
  );
endinterface

// File: rtl/multicycle_outdec.sv
// rtl/multicycle_outdec.sv - combinational state/opcode to control word decoder
module multicycle_outdec
  import mips_ctrl_pkg::*;
#(
  parameter int HAS_JAL = 1
) (
  input  state_t     state,
  input  logic [5:0] op,
  input  logic       rd_flag,
  output ctrl_word_t cw
);

  logic is_jal;
  assign is_jal = (HAS_JAL != 0) && (op == OP_JAL);

  // Map the current state (and opcode where it matters) to the raw control word
  always_comb begin
    cw = '0;
    case (state)
      S_FETCH: begin
        cw.mem_req = 1'b1;
        cw.alusrcb = SRCB_FOUR;
        cw.aluop   = ALU_ADD;
        cw.pcsrc   = PCSRC_ALU;
        cw.irwrite = 1'b1;
        cw.pcwrite = 1'b1;
      end
      S_DECODE: begin
        cw.alusrcb = SRCB_IMMSH;
        cw.aluop   = ALU_ADD;
        cw.hassign = 1'b1;
      end
      S_MEMADR: begin
        cw.alusrca = 1'b1;
        cw.alusrcb = SRCB_IMM;
        cw.aluop   = ALU_ADD;
        cw.hassign = 1'b1;
      end
      S_MEMRD: begin
        cw.mem_req = 1'b1;
        cw.iord    = 1'b1;
      end
      S_MEMWR: begin
        cw.mem_req  = 1'b1;
        cw.iord     = 1'b1;
        cw.memwrite = 1'b1;
      end
      S_MEMWB: begin
        cw.regwrite = 1'b1;
        cw.memtoreg = 1'b1;
      end
      S_RTEXE: begin
        cw.alusrca = 1'b1;
        cw.alusrcb = SRCB_RT;
        cw.aluop   = ALU_FUNCT;
      end
      S_ALUWB: begin
        cw.regwrite = 1'b1;
        cw.regdst   = rd_flag;
      end
      S_IMMEXE: begin
        cw.alusrca = 1'b1;
        cw.alusrcb = SRCB_IMM;
        case (op)
          OP_ADDI:  begin cw.aluop = ALU_ADD; cw.hassign = 1'b1; end
          OP_ADDIU: cw.aluop = ALU_ADD;
          OP_SLTI:  begin cw.aluop = ALU_SLT; cw.hassign = 1'b1; end
          OP_SLTIU: cw.aluop = ALU_SLT;
          OP_ANDI:  cw.aluop = ALU_AND;
          OP_ORI:   cw.aluop = ALU_OR;
          OP_XORI:  cw.aluop = ALU_XOR;
          OP_LUI:   begin cw.aluop = ALU_ADD; cw.islui = 1'b1; end
          default:  cw.aluop = ALU_ADD;
        endcase
      end
      S_BEQ: begin
        cw.alusrca = 1'b1;
        cw.alusrcb = SRCB_RT;
        cw.aluop   = ALU_SUB;
        cw.branch  = 1'b1;
        cw.pcsrc   = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        cw.pcwrite  = 1'b1;
        cw.pcsrc    = PCSRC_JUMP;
        cw.regwrite = is_jal;
        cw.link     = is_jal;
      end
      S_TRAP: cw.illegal = 1'b1;
      default: cw = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle MIPS main control FSM with memory handshake and timeout
module multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int ALUOP_W = 3,
  parameter int HAS_JAL = 1,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  multicycle_ctrl_if.master bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             rd_flag;
  ctrl_word_t       cw;
  logic             wait_st;
  logic             timeout;
  logic             strobe_ok;

  // States that wait on mem_ready; it is ignored everywhere else
  assign wait_st = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);

  // wait_cnt holds the number of wait cycles already spent, so the cycle in
  // which it equals TIMEOUT-1 with no ready is the TIMEOUT-th wait cycle.
  // A ready in that same cycle wins and the access completes.
  assign timeout = wait_st && !bus.mem_ready && (wait_cnt == CNT_W'(TIMEOUT - 1));

  // Write strobes fire only when a waited access actually completes
  assign strobe_ok = (!wait_st || bus.mem_ready) && !timeout;

  // State sequencing, wait counter and regdst-origin flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      rd_flag  <= 1'b0;
    end else begin
      wait_cnt <= '0;
      case (state)
        S_IDLE: state <= S_FETCH;
        S_FETCH: begin
          if (bus.mem_ready)  state <= S_DECODE;
          else if (timeout)   state <= S_FETCH;
          else                wait_cnt <= wait_cnt + 1'b1;
        end
        S_DECODE: begin
          case (bus.op)
            OP_LW, OP_SW: state <= S_MEMADR;
            OP_RTYPE:     state <= S_RTEXE;
            OP_BEQ:       state <= S_BEQ;
            OP_J:         state <= S_JUMP;
            OP_JAL:       state <= (HAS_JAL != 0) ? S_JUMP : S_TRAP;
            default:      state <= is_imm_op(bus.op) ? S_IMMEXE : S_TRAP;
          endcase
        end
        S_MEMADR: state <= (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD: begin
          if (bus.mem_ready)  state <= S_MEMWB;
          else if (timeout)   state <= S_FETCH;
          else                wait_cnt <= wait_cnt + 1'b1;
        end
        S_MEMWR: begin
          if (bus.mem_ready || timeout) state <= S_FETCH;
          else                          wait_cnt <= wait_cnt + 1'b1;
        end
        S_RTEXE: begin
          rd_flag <= 1'b1;
          state   <= S_ALUWB;
        end
        S_IMMEXE: begin
          rd_flag <= 1'b0;
          state   <= S_ALUWB;
        end
        S_MEMWB, S_ALUWB, S_BEQ, S_JUMP, S_TRAP: state <= S_FETCH;
        default: state <= S_IDLE;
      endcase
    end
  end

  multicycle_outdec #(
    .HAS_JAL (HAS_JAL)
  ) u_outdec (
    .state   (state),
    .op      (bus.op),
    .rd_flag (rd_flag),
    .cw      (cw)
  );

  assign bus.pcwrite  = cw.pcwrite & strobe_ok;
  assign bus.irwrite  = cw.irwrite & strobe_ok;
  assign bus.regwrite = cw.regwrite & ~timeout;
  assign bus.memwrite = cw.memwrite & ~timeout;
  assign bus.branch   = cw.branch;
  assign bus.iord     = cw.iord;
  assign bus.mem_req  = cw.mem_req;
  assign bus.regdst   = cw.regdst;
  assign bus.memtoreg = cw.memtoreg;
  assign bus.link     = cw.link;
  assign bus.alusrca  = cw.alusrca;
  assign bus.alusrcb  = cw.alusrcb;
  assign bus.pcsrc    = cw.pcsrc;
  assign bus.aluop    = ALUOP_W'(cw.aluop);
  assign bus.hassign  = cw.hassign;
  assign bus.islui    = cw.islui;
  assign bus.illegal  = cw.illegal;
  assign bus.bus_err  = timeout;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;
  import mips_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_wr, n_err, n_ir, n_notfetch, first_err;

  always #5 clk = ~clk;

  multicycle_ctrl_if #(.ALUOP_W(3)) bus ();
  multicycle_ctrl_if #(.ALUOP_W(3)) bus2 ();

  assign bus2.op        = bus.op;
  assign bus2.mem_ready = bus.mem_ready;

  multicycle_ctrl #(.ALUOP_W(3), .HAS_JAL(1), .TIMEOUT(15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  multicycle_ctrl #(.ALUOP_W(3), .HAS_JAL(0), .TIMEOUT(15)) dut_nojal (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [21:0] outs();
    return {bus.pcwrite, bus.branch, bus.iord, bus.mem_req, bus.memwrite,
            bus.irwrite, bus.regdst, bus.regwrite, bus.memtoreg, bus.link,
            bus.alusrca, bus.alusrcb, bus.pcsrc, bus.aluop, bus.hassign,
            bus.islui, bus.illegal, bus.bus_err};
  endfunction

  initial begin
    rst_n = 1'b0;
    bus.op = OP_LW;
    bus.mem_ready = 1'b1;
    #1;
    check("rst_state", 32'(dut.state), 32'(S_IDLE));
    check("rst_outs", 32'(outs()), 0);
    tick(); tick();
    rst_n = 1'b1;
    #1 check("idle_state", 32'(dut.state), 32'(S_IDLE));

    // LW, zero-wait memory
    tick(); #1;
    check("lw_fetch_state", 32'(dut.state), 32'(S_FETCH));
    check("lw_fetch_memreq", 32'(bus.mem_req), 1);
    check("lw_fetch_irwrite", 32'(bus.irwrite), 1);
    check("lw_fetch_pcwrite", 32'(bus.pcwrite), 1);
    check("lw_fetch_srcb", 32'(bus.alusrcb), 1);
    tick(); #1;
    check("lw_decode_state", 32'(dut.state), 32'(S_DECODE));
    check("lw_decode_srcb", 32'(bus.alusrcb), 3);
    check("lw_decode_hassign", 32'(bus.hassign), 1);
    tick(); #1;
    check("lw_memadr_state", 32'(dut.state), 32'(S_MEMADR));
    check("lw_memadr_srca", 32'(bus.alusrca), 1);
    check("lw_memadr_srcb", 32'(bus.alusrcb), 2);
    tick(); #1;
    check("lw_memrd_state", 32'(dut.state), 32'(S_MEMRD));
    check("lw_memrd_iord", 32'(bus.iord), 1);
    check("lw_memrd_memwrite", 32'(bus.memwrite), 0);
    tick(); #1;
    check("lw_memwb_state", 32'(dut.state), 32'(S_MEMWB));
    check("lw_memwb_regwrite", 32'(bus.regwrite), 1);
    check("lw_memwb_memtoreg", 32'(bus.memtoreg), 1);
    check("lw_memwb_regdst", 32'(bus.regdst), 0);
    tick(); #1;
    check("lw_end_state", 32'(dut.state), 32'(S_FETCH));

    // SW with three wait cycles in MEMWR
    bus.op = OP_SW;
    tick(); tick(); tick();
    check("sw_memwr_state", 32'(dut.state), 32'(S_MEMWR));
    n_wr = 0; n_err = 0;
    for (int k = 0; k < 4; k++) begin
      bus.mem_ready = (k >= 3);
      #1;
      if (bus.memwrite) n_wr++;
      if (bus.bus_err) n_err++;
      tick();
    end
    #1;
    check("sw_memwrite_cycles", 32'(n_wr), 4);
    check("sw_no_bus_err", 32'(n_err), 0);
    check("sw_end_state", 32'(dut.state), 32'(S_FETCH));

    // FETCH with mem_ready stuck low
    first_err = 0; n_err = 0; n_ir = 0; n_notfetch = 0;
    for (int k = 1; k <= 20; k++) begin
      bus.mem_ready = 1'b0;
      #1;
      if (bus.bus_err) begin
        n_err++;
        if (first_err == 0) first_err = k;
      end
      if (bus.irwrite || bus.pcwrite) n_ir++;
      tick();
      if (dut.state != S_FETCH) n_notfetch++;
    end
    check("to_first_cycle", 32'(first_err), 15);
    check("to_pulse_count", 32'(n_err), 1);
    check("to_no_strobe", 32'(n_ir), 0);
    check("to_stays_fetch", 32'(n_notfetch), 0);

    // SLTI
    bus.op = OP_SLTI;
    bus.mem_ready = 1'b1;
    tick(); tick(); #1;
    check("slti_state", 32'(dut.state), 32'(S_IMMEXE));
    check("slti_aluop", 32'(bus.aluop), 3);
    check("slti_hassign", 32'(bus.hassign), 1);
    tick(); #1;
    check("slti_aluwb_state", 32'(dut.state), 32'(S_ALUWB));
    check("slti_regdst", 32'(bus.regdst), 0);
    check("slti_regwrite", 32'(bus.regwrite), 1);
    tick();

    // LUI
    bus.op = OP_LUI;
    tick(); tick(); #1;
    check("lui_islui", 32'(bus.islui), 1);
    check("lui_aluop", 32'(bus.aluop), 0);
    tick(); tick();

    // R-type
    bus.op = OP_RTYPE;
    tick(); tick(); #1;
    check("rt_state", 32'(dut.state), 32'(S_RTEXE));
    check("rt_aluop", 32'(bus.aluop), 2);
    tick(); #1;
    check("rt_regdst", 32'(bus.regdst), 1);
    tick();

    // BEQ
    bus.op = OP_BEQ;
    tick(); tick(); #1;
    check("beq_branch", 32'(bus.branch), 1);
    check("beq_pcsrc", 32'(bus.pcsrc), 1);
    check("beq_aluop", 32'(bus.aluop), 1);
    tick(); #1;
    check("beq_end_state", 32'(dut.state), 32'(S_FETCH));

    // Undefined opcode
    bus.op = 6'b111111;
    tick(); #1;
    check("ill_decode_low", 32'(bus.illegal), 0);
    tick(); #1;
    check("ill_trap_high", 32'(bus.illegal), 1);
    tick(); #1;
    check("ill_after_low", 32'(bus.illegal), 0);
    check("ill_after_state", 32'(dut.state), 32'(S_FETCH));

    // JAL on both configurations
    bus.op = OP_JAL;
    tick(); tick(); #1;
    check("jal_pcwrite", 32'(bus.pcwrite), 1);
    check("jal_link", 32'(bus.link), 1);
    check("jal_regwrite", 32'(bus.regwrite), 1);
    check("jal_pcsrc", 32'(bus.pcsrc), 2);
    check("nojal_illegal", 32'(bus2.illegal), 1);
    check("nojal_link", 32'(bus2.link), 0);
    tick();

    // Reset asserted while waiting in MEMRD
    bus.op = OP_LW;
    tick(); tick(); tick();
    bus.mem_ready = 1'b0;
    tick(); #1;
    check("mrd_state", 32'(dut.state), 32'(S_MEMRD));
    check("mrd_memreq", 32'(bus.mem_req), 1);
    check("mrd_cnt", 32'(dut.wait_cnt), 1);
    rst_n = 1'b0;
    #1;
    check("arst_outs", 32'(outs()), 0);
    check("arst_state", 32'(dut.state), 32'(S_IDLE));
    check("arst_cnt", 32'(dut.wait_cnt), 0);
    tick();
    rst_n = 1'b1;
    bus.mem_ready = 1'b1;
    #1 check("rel_idle", 32'(dut.state), 32'(S_IDLE));
    tick(); #1;
    check("rel_fetch", 32'(dut.state), 32'(S_FETCH));
    check("rel_memreq", 32'(bus.mem_req), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle main control unit for the MIPS datapath, and the sequential successor to the single-cycle main decoder. It sequences fetch, decode, execute, memory and writeback over several cycles. It stalls on a memory ready handshake and guards each memory access with a timeout counter. It sits between the instruction register opcode field and the multicycle datapath's enables and muxes.

## Interface
- `ALUOP_W`, default 3: width of `aluop`; must be at least 3, and upper bits are driven 0.
- `HAS_JAL`, default 1: 1 decodes JAL (op 000011); 0 treats it as illegal.
- `TIMEOUT`, default 15: maximum wait cycles for `mem_ready`; must be at least 1.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `op` in 6: opcode, `instr[31:26]`, taken from the instruction register.
- `mem_ready` in 1: memory completes the current access this cycle.
- `pcwrite` out 1: unconditional PC load.
- `branch` out 1: PC load if the ALU zero flag is set.
- `iord` out 1: 1 selects the ALUOut address, 0 selects the PC address.
- `mem_req` out 1: memory access active.
- `memwrite` out 1: the access is a write.
- `irwrite` out 1: load the instruction register.
- `regdst` out 1: 1 selects rd, 0 selects rt.
- `regwrite` out 1: register file write enable.
- `memtoreg` out 1: 1 selects MDR for writeback.
- `link` out 1: write PC to register $31 (JAL).
- `alusrca` out 1: 1 selects rs, 0 selects PC.
- `alusrcb` out 2: 00 selects rt, 01 selects constant 4, 10 selects the extended immediate, 11 selects the immediate shifted left by 2.
- `pcsrc` out 2: 00 selects the ALU result, 01 selects ALUOut, 10 selects the jump target.
- `aluop` out ALUOP_W: 000 add, 001 sub, 010 funct-decoded, 011 slt, 100 and, 101 or, 110 xor.
- `hassign` out 1: sign-extend the immediate; signed compare or overflow.
- `islui` out 1: immediate shifted left by 16.
- `illegal` out 1: one-cycle pulse on an undefined opcode.
- `bus_err` out 1: one-cycle pulse on a memory timeout.

## Operation
- States: IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEXE, ALUWB, IMMEXE, BEQ, JUMP, TRAP.
- While `rst_n` is low the state is IDLE. In IDLE every output is 0. IDLE always moves to FETCH on the next cycle.
- **FETCH:** drives `mem_req`=1, `iord`=0, `alusrca`=0, `alusrcb`=01, `aluop`=000 and `pcsrc`=00.
  - `irwrite` and `pcwrite` are asserted only in the cycle where `mem_ready`=1; that cycle moves to DECODE.
  - Otherwise FETCH holds.
- **DECODE:** drives `alusrca`=0, `alusrcb`=11, `aluop`=000 and `hassign`=1, computing the branch target. Next state by `op`:
  - LW and SW go to MEMADR.
  - R-type goes to RTEXE.
  - BEQ goes to BEQ.
  - ADDI, ADDIU, SLTI, SLTIU, ANDI, ORI, XORI and LUI go to IMMEXE.
  - J goes to JUMP; JAL goes to JUMP when `HAS_JAL`=1.
  - Any other opcode goes to TRAP.
- **MEMADR:** `alusrca`=1, `alusrcb`=10, `aluop`=000, `hassign`=1. Moves to MEMRD for LW, MEMWR for SW.
- **MEMRD and MEMWR:** `mem_req`=1, `iord`=1, with `memwrite`=1 in MEMWR only. These states hold until `mem_ready`=1.
  - On `mem_ready`, MEMRD moves to MEMWB and MEMWR moves to FETCH.
- **MEMWB:** `regwrite`=1, `regdst`=0, `memtoreg`=1, then FETCH.
- **RTEXE:** `alusrca`=1, `alusrcb`=00, `aluop`=010, then ALUWB.
- **ALUWB:** `regwrite`=1, `memtoreg`=0. `regdst` is 1 when reached from RTEXE and 0 when reached from IMMEXE; the origin is held in a 1-bit flag. Then FETCH.
- **IMMEXE:** `alusrca`=1, `alusrcb`=10, then ALUWB. Per opcode:
  - ADDI: `aluop`=000, `hassign`=1.
  - ADDIU: `aluop`=000, `hassign`=0.
  - SLTI: `aluop`=011, `hassign`=1.
  - SLTIU: `aluop`=011, `hassign`=0.
  - ANDI: `aluop`=100.
  - ORI: `aluop`=101.
  - XORI: `aluop`=110.
  - LUI: `aluop`=000, `islui`=1.
- **BEQ:** `alusrca`=1, `alusrcb`=00, `aluop`=001, `branch`=1, `pcsrc`=01, then FETCH.
- **JUMP:** `pcwrite`=1, `pcsrc`=10. For JAL it also drives `regwrite`=1 and `link`=1. Then FETCH.
- **TRAP:** `illegal`=1 for one cycle, then FETCH. The PC was already incremented in FETCH.
- **Timeout:** a wait counter of width clog2(TIMEOUT+1) clears on entry to FETCH, MEMRD and MEMWR, and increments each cycle `mem_ready`=0.
  - When the count reaches TIMEOUT with `mem_ready` still 0, the block pulses `bus_err` and goes to FETCH.
  - The aborted access suppresses `irwrite`, `pcwrite`, `regwrite` and `memwrite` in that cycle.
- Signals not listed for a state are 0.

## Timing
- All outputs are decoded combinationally from the state register. The `irwrite`/`pcwrite` strobes are additionally gated by `mem_ready` in FETCH.
- With zero-wait memory, instruction latency in cycles: LW 5, SW 4, R-type and immediate ops 4, BEQ 3, J and JAL 3.
- `mem_ready` is sampled only in FETCH, MEMRD and MEMWR; it is ignored elsewhere.
- Simultaneous `mem_ready`=1 and timeout count reached: `mem_ready` wins and the access completes.
- Reset asserted mid-instruction: the block goes to IDLE immediately, with all outputs 0 in the same cycle (asynchronous). The counter and the regdst flag clear.

## Structure
- A shared package `mips_ctrl_pkg` holds:
  - opcode constants;
  - `aluop` codes;
  - the `alusrcb` and `pcsrc` encodings;
  - the state enum.
- One combinational sub-module, `multicycle_outdec`, maps the state, `op` and the regdst flag to the control word. The FSM, counter and gating stay in the top module.

## Test plan
- LW with `mem_ready` tied to 1: states run IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH. `regwrite`=1 and `memtoreg`=1 in cycle 5.
- SW with `mem_ready` low for 3 cycles in MEMWR: `memwrite`=1 is held for 4 cycles, then the state is FETCH. No `bus_err`.
- FETCH with `mem_ready` stuck at 0 and `TIMEOUT`=15: `bus_err` pulses once at the 15th wait cycle. `irwrite` never asserts. The state returns to FETCH.
- SLTI (op 001010): IMMEXE shows `aluop`=011 and `hassign`=1. ALUWB shows `regdst`=0. LUI (op 001111) shows `islui`=1.
- Op 111111: `illegal` is high for exactly 1 cycle after DECODE. With `HAS_JAL`=0, op 000011 also traps.
- `rst_n` pulled low during MEMRD: all outputs are 0 in the same cycle. After release, the cycle after IDLE is FETCH with `mem_req`=1.
